// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel timer peripheral.
// Register offsets, field bit positions and channel window helpers.
package timer_pkg;

  localparam int MAX_NUM_CH = 8;
  localparam int MAX_CNT_W  = 32;

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_PRESC  = 8'h04;
  localparam logic [7:0] OFS_COUNT  = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;
  localparam logic [7:0] OFS_IRQ_EN = 8'h10;

  localparam logic [7:0] CH_BASE   = 8'h20;
  localparam int         CH_STRIDE = 16;

  localparam logic [1:0] CH_CMP    = 2'd0;
  localparam logic [1:0] CH_PERIOD = 2'd1;
  localparam logic [1:0] CH_CFG    = 2'd2;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CFG_EN   = 0;
  localparam int CFG_PER  = 1;

  // True when word address a selects register sub of channel ch.
  function automatic logic ch_hit(
    input logic [7:0] a,
    input int         ch,
    input logic [1:0] sub
  );
    logic [7:0] rel;
    rel = a - CH_BASE;
    return (a >= CH_BASE)
        && (rel[7:4] == ch[3:0])
        && (rel[3:2] == sub);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare channel: CMP, PERIOD, CFG and pending flag.
// Handles match detection, periodic advance and one-shot disable.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] count_i,
  input  logic             tick_i,
  input  logic             cmp_we_i,
  input  logic             per_we_i,
  input  logic             cfg_we_i,
  input  logic             w1c_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic [3:0]       sel_i,
  output logic [CNT_W-1:0] cmp_o,
  output logic [CNT_W-1:0] period_o,
  output logic             ch_en_o,
  output logic             periodic_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             en_q, en_d;
  logic             pmode_q, pmode_d;
  logic             pend_q, pend_d;
  logic             match;

  // Match, hardware updates, then software writes override.
  always_comb begin
    match   = tick_i & en_q & (count_i == cmp_q);
    cmp_d   = cmp_q;
    per_d   = per_q;
    en_d    = en_q;
    pmode_d = pmode_q;
    pend_d  = pend_q;
    if (match & pmode_q)  cmp_d = cmp_q + per_q;
    if (match & ~pmode_q) en_d  = 1'b0;
    for (int b = 0; b < CNT_W; b++) begin
      if (cmp_we_i & sel_i[b>>3]) cmp_d[b] = wdata_i[b];
      if (per_we_i & sel_i[b>>3]) per_d[b] = wdata_i[b];
    end
    if (cfg_we_i) begin
      en_d    = wdata_i[CFG_EN];
      pmode_d = wdata_i[CFG_PER];
    end
    if (w1c_i) pend_d = 1'b0;
    if (match) pend_d = 1'b1;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q   <= '0;
      per_q   <= '0;
      en_q    <= 1'b0;
      pmode_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cmp_q   <= cmp_d;
      per_q   <= per_d;
      en_q    <= en_d;
      pmode_q <= pmode_d;
      pend_q  <= pend_d;
    end
  end

  assign cmp_o      = cmp_q;
  assign period_o   = per_q;
  assign ch_en_o    = en_q;
  assign periodic_o = pmode_q;
  assign pending_o  = pend_q;

endmodule

// File: rtl/multi_channel_timer.sv
// Memory-mapped timer: prescaler, shared counter, NUM_CH compares.
// Bus decode, registered read mux and interrupt reduction live here.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  input  logic              we_i,
  output logic [31:0]       data_o,
  output logic [NUM_CH-1:0] irq_ch_o,
  output logic              irq_o
);

  logic [7:0]         a;
  logic               ctrl_we, presc_we;
  logic               sts_we, ien_we;
  logic               clr, tick;
  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_CH-1:0]  ien_q, ien_d;
  logic [31:0]        data_q, data_d;

  logic [CNT_W-1:0]   cmp [NUM_CH];
  logic [CNT_W-1:0]   per [NUM_CH];
  logic [NUM_CH-1:0]  ch_en, periodic, pending;
  logic [NUM_CH-1:0]  cmp_we, per_we;
  logic [NUM_CH-1:0]  cfg_we, w1c;

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:8], addr_i[1:0]};

  // Address decode into per-register write strobes.
  always_comb begin
    a        = {addr_i[7:2], 2'b00};
    ctrl_we  = we_i & (a == OFS_CTRL);
    presc_we = we_i & (a == OFS_PRESC);
    sts_we   = we_i & (a == OFS_STATUS);
    ien_we   = we_i & (a == OFS_IRQ_EN);
    clr      = ctrl_we & sel_i[0] & data_i[CTRL_CLR];
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_we[i] = we_i & ch_hit(a, i, CH_CMP);
      per_we[i] = we_i & ch_hit(a, i, CH_PERIOD);
      cfg_we[i] = we_i & sel_i[0]
                & ch_hit(a, i, CH_CFG);
      w1c[i]    = sts_we & sel_i[0] & data_i[i];
    end
  end

  // Global control registers: enable, divisor, irq enables.
  always_comb begin
    en_d    = en_q;
    presc_d = presc_q;
    ien_d   = ien_q;
    if (ctrl_we & sel_i[0]) en_d = data_i[CTRL_EN];
    for (int b = 0; b < PRESC_W; b++) begin
      if (presc_we & sel_i[b>>3]) presc_d[b] = data_i[b];
    end
    if (ien_we & sel_i[0]) ien_d = data_i[NUM_CH-1:0];
  end

  // Prescaler and counter; clr suppresses the tick it lands on.
  // Restart also if the divisor shrank below the running count.
  always_comb begin
    tick = en_q & (psc_q == presc_q) & ~clr;
    if (clr | ~en_q | (psc_q >= presc_q)) psc_d = '0;
    else psc_d = psc_q + PRESC_W'(1);
    if (clr) count_d = '0;
    else if (tick) count_d = count_q + CNT_W'(1);
    else count_d = count_q;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .count_i   (count_q),
      .tick_i    (tick),
      .cmp_we_i  (cmp_we[i]),
      .per_we_i  (per_we[i]),
      .cfg_we_i  (cfg_we[i]),
      .w1c_i     (w1c[i]),
      .wdata_i   (data_i[CNT_W-1:0]),
      .sel_i     (sel_i),
      .cmp_o     (cmp[i]),
      .period_o  (per[i]),
      .ch_en_o   (ch_en[i]),
      .periodic_o(periodic[i]),
      .pending_o (pending[i])
    );
  end

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    data_d = '0;
    unique case (1'b1)
      (a == OFS_CTRL):   data_d[CTRL_EN] = en_q;
      (a == OFS_PRESC):  data_d[PRESC_W-1:0] = presc_q;
      (a == OFS_COUNT):  data_d[CNT_W-1:0] = count_q;
      (a == OFS_STATUS): data_d[NUM_CH-1:0] = pending;
      (a == OFS_IRQ_EN): data_d[NUM_CH-1:0] = ien_q;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_hit(a, i, CH_CMP))
            data_d[CNT_W-1:0] = cmp[i];
          if (ch_hit(a, i, CH_PERIOD))
            data_d[CNT_W-1:0] = per[i];
          if (ch_hit(a, i, CH_CFG)) begin
            data_d[CFG_EN]  = ch_en[i];
            data_d[CFG_PER] = periodic[i];
          end
        end
      end
    endcase
  end

  // Global state and read data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      presc_q <= '0;
      psc_q   <= '0;
      count_q <= '0;
      ien_q   <= '0;
      data_q  <= '0;
    end else begin
      en_q    <= en_d;
      presc_q <= presc_d;
      psc_q   <= psc_d;
      count_q <= count_d;
      ien_q   <= ien_d;
      data_q  <= data_d;
    end
  end

  assign data_o   = data_q;
  assign irq_ch_o = pending & ien_q;
  assign irq_o    = |irq_ch_o;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Randomized bench for multi_channel_timer with a register-level model.
// Small CNT_W keeps the counter wrap reachable in a short run.
module tb_multi_channel_timer;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 12;
  localparam int PRESC_W = 16;
  localparam int unsigned CMASK = (1 << CNT_W) - 1;
  localparam int unsigned PMASK = (1 << PRESC_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       addr_i, data_i;
  logic [3:0]        sel_i;
  logic              we_i;
  logic [31:0]       data_o;
  logic [NUM_CH-1:0] irq_ch_o;
  logic              irq_o;

  int n_vec = 0;
  int n_err = 0;

  multi_channel_timer #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .sel_i   (sel_i),
    .we_i    (we_i),
    .data_o  (data_o),
    .irq_ch_o(irq_ch_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  bit          m_en;
  int unsigned m_presc, m_psc, m_cnt;
  int unsigned m_cmp [NUM_CH];
  int unsigned m_per [NUM_CH];
  bit          m_chen [NUM_CH];
  bit          m_pmode [NUM_CH];
  bit          m_pend [NUM_CH];
  bit          m_ie [NUM_CH];
  logic [31:0] e_data;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_presc = 0; m_psc = 0; m_cnt = 0;
    e_data = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cmp[i] = 0; m_per[i] = 0; m_chen[i] = 0;
      m_pmode[i] = 0; m_pend[i] = 0; m_ie[i] = 0;
    end
  endtask

  function automatic int unsigned merge(input int unsigned old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] r;
    r = 0;
    if (a == 8'h00) r[0] = m_en;
    else if (a == 8'h04) r = m_presc;
    else if (a == 8'h08) r = m_cnt;
    else if (a == 8'h0C)
      for (int i = 0; i < NUM_CH; i++) r[i] = m_pend[i];
    else if (a == 8'h10)
      for (int i = 0; i < NUM_CH; i++) r[i] = m_ie[i];
    else
      for (int i = 0; i < NUM_CH; i++) begin
        if (a == 32 + 16*i) r = m_cmp[i];
        if (a == 36 + 16*i) r = m_per[i];
        if (a == 40 + 16*i) r = {30'd0, m_pmode[i], m_chen[i]};
      end
    return r;
  endfunction

  function automatic logic [31:0] m_irq();
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < NUM_CH; i++) r[i] = m_pend[i] & m_ie[i];
    return r;
  endfunction

  function automatic bit pred_match0();
    return m_en && (m_psc == m_presc) && m_chen[0]
        && (m_cnt == m_cmp[0]);
  endfunction

  // One clock edge of the model: bus access plus timer rules.
  task automatic model_step(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic w);
    bit clr, tick;
    bit hit [NUM_CH];
    e_data = m_read(a);
    clr  = w && (a == 8'h00) && s[0] && d[1];
    tick = m_en && (m_psc == m_presc) && !clr;
    for (int i = 0; i < NUM_CH; i++)
      hit[i] = tick && m_chen[i] && (m_cnt == m_cmp[i]);
    if (clr || !m_en || m_psc >= m_presc) m_psc = 0;
    else m_psc = m_psc + 1;
    if (clr) m_cnt = 0;
    else if (tick) m_cnt = (m_cnt + 1) & CMASK;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w && a == 8'h0C && s[0] && d[i]) m_pend[i] = 0;
      if (hit[i]) begin
        m_pend[i] = 1;
        if (m_pmode[i]) m_cmp[i] = (m_cmp[i] + m_per[i]) & CMASK;
        else m_chen[i] = 0;
      end
    end
    if (w) begin
      if (a == 8'h00 && s[0]) m_en = d[0];
      if (a == 8'h04) m_presc = merge(m_presc, d, s) & PMASK;
      if (a == 8'h10 && s[0])
        for (int i = 0; i < NUM_CH; i++) m_ie[i] = d[i];
      for (int i = 0; i < NUM_CH; i++) begin
        if (a == 32 + 16*i) m_cmp[i] = merge(m_cmp[i], d, s) & CMASK;
        if (a == 36 + 16*i) m_per[i] = merge(m_per[i], d, s) & CMASK;
        if (a == 40 + 16*i && s[0]) begin
          m_chen[i] = d[0];
          m_pmode[i] = d[1];
        end
      end
    end
  endtask

  task automatic cyc(input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic w);
    logic [31:0] ei;
    addr_i = {24'd0, a};
    data_i = d;
    sel_i  = s;
    we_i   = w;
    @(posedge clk);
    model_step(a, d, s, w);
    @(negedge clk);
    ei = m_irq();
    chk("data_o", data_o, e_data);
    chk("irq_ch_o", 32'(irq_ch_o), ei);
    chk("irq_o", 32'(irq_o), 32'(|ei));
    we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(a, d, 4'hF, 1'b1);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(a, 32'd0, 4'h0, 1'b0);
  endtask

  initial begin
    int rises[$];
    bit prev, cur, w1c, found;
    logic [7:0] alist[$];
    logic [7:0] ra;
    logic [31:0] rdv;
    logic [3:0] rs;

    rst_n = 0; addr_i = 0; data_i = 0; sel_i = 0; we_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data", data_o, 0);
    chk("rst_irq_ch", 32'(irq_ch_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    rst_n = 1;
    rd(8'h08);

    // one-shot on channel 0
    wr(8'h04, 0); wr(8'h20, 5); wr(8'h28, 1); wr(8'h10, 1);
    wr(8'h00, 1);
    for (int k = 1; k <= 6; k++) begin
      rd(8'h28);
      if (k == 5) chk("t1_early", 32'(irq_o), 0);
      if (k == 6) chk("t1_irq", 32'(irq_o), 1);
    end
    rd(8'h28);
    chk("t1_chen", data_o, 0);

    // periodic channel 1, prescaled by 4
    wr(8'h00, 2); wr(8'h0C, 32'hF);
    wr(8'h04, 3); wr(8'h30, 2); wr(8'h34, 4); wr(8'h38, 3);
    wr(8'h10, 2); wr(8'h00, 1);
    prev = 0; w1c = 0;
    for (int c = 0; c < 120 && rises.size() < 3; c++) begin
      if (w1c) cyc(8'h0C, 32'h2, 4'h1, 1'b1);
      else rd(8'h0C);
      cur = irq_ch_o[1];
      w1c = cur && !prev;
      if (w1c) rises.push_back(c);
      prev = cur;
    end
    chk("t2_rises", 32'(rises.size()), 3);
    if (rises.size() == 3) begin
      chk("t2_gap1", 32'(rises[1] - rises[0]), 16);
      chk("t2_gap2", 32'(rises[2] - rises[1]), 16);
    end
    rd(8'h30);
    chk("t2_cmp1", data_o, 14);

    // wrap match with periodic advance
    wr(8'h00, 2); wr(8'h38, 0); wr(8'h0C, 32'hF);
    wr(8'h10, 1); wr(8'h20, 32'hFFFF_FFFF); wr(8'h24, 2);
    wr(8'h28, 3); wr(8'h04, 0); wr(8'h00, 1);
    found = 0;
    for (int c = 0; c < 4200 && !found; c++) begin
      rd(8'h20);
      found = irq_ch_o[0];
    end
    chk("t3_hit", 32'(found), 1);
    rd(8'h20);
    chk("t3_cmp0", data_o, 1);

    // W1C colliding with a match: set wins
    wr(8'h0C, 1);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (pred_match0()) begin
        cyc(8'h0C, 32'h1, 4'h1, 1'b1);
        found = 1;
      end else rd(8'h0C);
    end
    chk("t4_seen", 32'(found), 1);
    rd(8'h0C);
    chk("t4_set_wins", 32'(data_o[0]), 1);

    // clr at count 9 suppresses the match
    wr(8'h00, 3); wr(8'h20, 9); wr(8'h28, 1); wr(8'h0C, 32'hF);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (m_cnt == 9) begin
        wr(8'h00, 3);
        found = 1;
      end else rd(8'h0C);
    end
    chk("t4_clr_seen", 32'(found), 1);
    rd(8'h08);
    chk("t4_clr_count", data_o, 0);
    rd(8'h0C);
    chk("t4_no_match", 32'(data_o[0]), 0);

    // byte-lane write and unmapped read
    cyc(8'h40, 32'hAABB_CCDD, 4'b0010, 1'b1);
    rd(8'h40);
    chk("t5_cmp2", data_o, 32'h0000_0C00);
    rd(8'h00);
    chk("t5_ctrl", data_o, 1);
    rd(8'h1C);
    chk("t5_unmapped", data_o, 0);

    // random traffic
    alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h1C,
              8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38,
              8'h40, 8'h44, 8'h48, 8'h50, 8'h54, 8'h58, 8'h60,
              8'h64, 8'hA0};
    for (int n = 0; n < 3000; n++) begin
      ra = alist[$urandom_range(0, alist.size() - 1)];
      if (ra == 8'h00)
        rdv = {30'd0, ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) != 0)};
      else if (ra == 8'h04)
        rdv = $urandom_range(0, 3);
      else if (ra >= 8'h20 && ra[3:2] == 2'd0)
        rdv = (m_cnt + $urandom_range(0, 23)) & CMASK;
      else
        rdv = $urandom;
      rs = ($urandom_range(0, 1) != 0) ? 4'hF
                                       : 4'($urandom_range(0, 15));
      cyc(ra, rdv, rs, 1'($urandom_range(0, 1)));
    end

    // asynchronous reset while running with irq high
    wr(8'h00, 1); wr(8'h04, 0); wr(8'h10, 32'hF); wr(8'h28, 1);
    wr(8'h20, (m_cnt + 6) & CMASK);
    found = irq_o;
    for (int c = 0; c < 40 && !found; c++) begin
      rd(8'h0C);
      found = irq_o;
    end
    chk("t6_pre_irq", 32'(irq_o), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_data", data_o, 0);
    chk("t6_irq_ch", 32'(irq_ch_o), 0);
    chk("t6_irq", 32'(irq_o), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) rd(8'h08);
    chk("t6_count", data_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
